// File: rtl/det101_rr_sched.sv
// det101_rr_sched: round-robin scheduler that time-shares one Moore "101"
// detector between N_REQ serial requesters. Each burst clears the detector,
// streams the owner's bits into it, then drains its latency. Matches seen
// during the stream and drain phases are attributed to the owner.
module det101_rr_sched #(
  parameter int N_REQ     = 4,
  parameter int LEN_W     = 8,
  parameter int DRAIN_CYC = 2,
  localparam int PW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] x_in,
  input  logic [LEN_W-1:0] len,
  input  logic             det_y,
  output logic             det_x,
  output logic             det_clr,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic [N_REQ-1:0] hit,
  output logic [LEN_W-1:0] hit_cnt,
  output logic             done,
  output logic [PW-1:0]    done_id
);

  typedef enum logic [2:0] {IDLE, CLR, STREAM, DRAIN, DONE} state_t;

  localparam logic [LEN_W-1:0] DRN_LAST = LEN_W'(DRAIN_CYC);

  state_t           state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    owner;
  logic [PW-1:0]    pick;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] bit_cnt;
  logic [LEN_W-1:0] drn_cnt;
  logic             det_live;

  // First requester at or above the pointer, wrapping modulo N_REQ.
  function automatic logic [PW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [PW-1:0] p);
    logic [PW-1:0] sel;
    logic          found;
    int            idx;
    sel   = p;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(p) + i) % N_REQ;
      if (!found && r[idx]) begin
        sel   = PW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // Pointer position just past the chosen owner.
  function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] o);
    return PW'((int'(o) + 1) % N_REQ);
  endfunction

  // Hit counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (v == {LEN_W{1'b1}}) ? v : v + LEN_W'(1);
  endfunction

  // A zero-length request still runs as a single-bit burst.
  function automatic logic [LEN_W-1:0] len_floor(input logic [LEN_W-1:0] l);
    return (l == '0) ? LEN_W'(1) : l;
  endfunction

  assign pick     = rr_pick(req, ptr);
  assign det_live = (state == STREAM) || (state == DRAIN);

  // Burst sequencing: grant, clear, stream, drain, report.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt     <= '0;
      hit_cnt <= '0;
      done    <= 1'b0;
      done_id <= '0;
      bit_cnt <= '0;
      drn_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            owner <= pick;
            ptr   <= rr_next(pick);
            len_q <= len_floor(len);
            gnt   <= N_REQ'(1) << pick;
            state <= CLR;
          end
        end
        CLR: begin
          hit_cnt <= '0;
          bit_cnt <= LEN_W'(1);
          state   <= STREAM;
        end
        STREAM: begin
          if (det_y) hit_cnt <= sat_inc(hit_cnt);
          if (bit_cnt == len_q) begin
            drn_cnt <= LEN_W'(1);
            state   <= DRAIN;
          end else begin
            bit_cnt <= bit_cnt + LEN_W'(1);
          end
        end
        DRAIN: begin
          if (det_y) hit_cnt <= sat_inc(hit_cnt);
          if (drn_cnt == DRN_LAST) begin
            gnt     <= '0;
            done    <= 1'b1;
            done_id <= owner;
            state   <= DONE;
          end else begin
            drn_cnt <= drn_cnt + LEN_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Detector-facing mux, clear, hit attribution and busy flag.
  always_comb begin
    det_x   = 1'b0;
    hit     = '0;
    det_clr = rst || (state == CLR);
    busy    = (state != IDLE);
    if (state == STREAM) det_x = x_in[owner];
    if (det_live && det_y) hit = N_REQ'(1) << owner;
  end

endmodule

// File: tb/tb_det101_rr_sched.sv
// Directed bench for det101_rr_sched with a behavioural Moore "101"
// detector attached to det_x/det_clr/det_y.
module tb_det101_rr_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] x_in = 4'b0000;
  logic [7:0] len = 8'd0;
  logic       det_y;
  logic       det_x;
  logic       det_clr;
  logic [3:0] gnt;
  logic       busy;
  logic [3:0] hit;
  logic [7:0] hit_cnt;
  logic       done;
  logic [1:0] done_id;

  int total = 0;
  int bad   = 0;

  logic [254:0] pat [4];
  int           plen [4];
  int           k [4];
  int           hits [4];
  int           oh_bad = 0;

  det101_rr_sched dut (
    .clk(clk), .rst(rst), .req(req), .x_in(x_in), .len(len),
    .det_y(det_y), .det_x(det_x), .det_clr(det_clr), .gnt(gnt),
    .busy(busy), .hit(hit), .hit_cnt(hit_cnt), .done(done), .done_id(done_id)
  );

  always #5 clk = ~clk;

  // Moore 101 detector: y registered one clock after reaching the 101 state.
  logic [1:0] ds;
  always @(posedge clk) begin
    if (det_clr) begin
      ds    <= 2'd0;
      det_y <= 1'b0;
    end else begin
      det_y <= (ds == 2'd3);
      case (ds)
        2'd0: ds <= det_x ? 2'd1 : 2'd0;
        2'd1: ds <= det_x ? 2'd1 : 2'd2;
        2'd2: ds <= det_x ? 2'd3 : 2'd0;
        default: ds <= det_x ? 2'd1 : 2'd2;
      endcase
    end
  end

  // Serial front-ends: channel c presents pat[c] starting the cycle after its CLR cycle.
  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (gnt[c]) k[c] = k[c] + 1;
      else        k[c] = 0;
      if (gnt[c] && k[c] >= 2 && (k[c] - 2) < plen[c]) x_in[c] = pat[c][k[c]-2];
      else x_in[c] = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic setpat(input int c, input logic [254:0] v, input int n);
    pat[c]  = v;
    plen[c] = n;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Request a burst and follow it to its done pulse, bounded by a cycle budget.
  task automatic run_burst(input logic [3:0] r, input logic [7:0] l,
                           output logic [3:0] g1, output int gcyc, output int lat,
                           output int id, output int hc, output logic clr0);
    bit ok;
    req  = r;
    len  = l;
    g1   = 4'b0000;
    gcyc = 0;
    lat  = 0;
    id   = -1;
    hc   = -1;
    clr0 = 1'b0;
    ok   = 1'b0;
    for (int c = 0; c < 4; c++) hits[c] = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) hits[c] += int'(hit[c]);
      if (gnt != 4'b0000) begin
        if (g1 == 4'b0000) begin
          g1   = gnt;
          clr0 = det_clr;
        end
        gcyc++;
        if ((gnt & (gnt - 4'd1)) != 4'b0000) oh_bad++;
      end
      if (g1 != 4'b0000) lat++;
      if (done) begin
        id = int'(done_id);
        hc = int'(hit_cnt);
        ok = 1'b1;
        break;
      end
    end
    chk("burst_finished", 32'(ok), 32'd1);
  endtask

  logic [3:0] g1;
  int gcyc, lat, id, hc, dcount;
  logic clr0;
  logic [3:0] exp_g;

  initial begin
    for (int c = 0; c < 4; c++) begin
      pat[c] = '0; plen[c] = 0; k[c] = 0;
    end

    // Reset state
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_clr", 32'(det_clr), 32'd1);
    chk("rst_hitcnt", 32'(hit_cnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_clr", 32'(det_clr), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_gnt", 32'(gnt), 32'd0);

    // Single burst, overlapping 10101 on ch0
    setpat(0, 255'b10101, 5);
    run_burst(4'b0001, 8'd5, g1, gcyc, lat, id, hc, clr0);
    req = 4'b0000;
    chk("b1_gnt", 32'(g1), 32'b0001);
    chk("b1_clr_at_grant", 32'(clr0), 32'd1);
    chk("b1_gnt_cycles", 32'(gcyc), 32'd8);
    chk("b1_latency", 32'(lat), 32'd9);
    chk("b1_hit0", 32'(hits[0]), 32'd2);
    chk("b1_hit_other", 32'(hits[1] + hits[2] + hits[3]), 32'd0);
    chk("b1_hitcnt", 32'(hc), 32'd2);
    chk("b1_id", 32'(id), 32'd0);
    @(negedge clk);
    chk("b1_hold_cnt", 32'(hit_cnt), 32'd2);
    chk("b1_idle_busy", 32'(busy), 32'd0);

    // Round robin with all requesters held
    do_reset();
    for (int c = 0; c < 4; c++) setpat(c, 255'b101, 3);
    for (int n = 0; n < 5; n++) begin
      run_burst(4'b1111, 8'd3, g1, gcyc, lat, id, hc, clr0);
      exp_g = 4'b0001 << (n % 4);
      chk("rr_gnt", 32'(g1), 32'(exp_g));
      chk("rr_id", 32'(id), 32'(n % 4));
      chk("rr_hitcnt", 32'(hc), 32'd1);
      chk("rr_hit_owner", 32'(hits[n % 4]), 32'd1);
      chk("rr_latency", 32'(lat), 32'd7);
      @(negedge clk);
      chk("rr_gap_busy", 32'(busy), 32'd0);
      chk("rr_gap_gnt", 32'(gnt), 32'd0);
    end
    req = 4'b0000;
    chk("onehot", 32'(oh_bad), 32'd0);

    // Zero length treated as one bit
    setpat(2, 255'b1, 1);
    @(negedge clk);
    run_burst(4'b0100, 8'd0, g1, gcyc, lat, id, hc, clr0);
    req = 4'b0000;
    chk("len0_gnt", 32'(g1), 32'b0100);
    chk("len0_gnt_cycles", 32'(gcyc), 32'd4);
    chk("len0_hitcnt", 32'(hc), 32'd0);
    chk("len0_id", 32'(id), 32'd2);

    // Longest burst: 127 x "10" then "1" -> 127 matches, no saturation
    setpat(3, {128{2'b01}}, 255);
    @(negedge clk);
    run_burst(4'b1000, 8'd255, g1, gcyc, lat, id, hc, clr0);
    req = 4'b0000;
    chk("long_gnt", 32'(g1), 32'b1000);
    chk("long_hitcnt", 32'(hc), 32'd127);
    chk("long_hits", 32'(hits[3]), 32'd127);
    chk("long_latency", 32'(lat), 32'd259);
    chk("long_id", 32'(id), 32'd3);

    // No carry-over between bursts on ch1
    setpat(1, 255'b01, 2);
    @(negedge clk);
    run_burst(4'b0010, 8'd2, g1, gcyc, lat, id, hc, clr0);
    req = 4'b0000;
    chk("carry_a_hitcnt", 32'(hc), 32'd0);
    setpat(1, 255'b1, 1);
    @(negedge clk);
    run_burst(4'b0010, 8'd1, g1, gcyc, lat, id, hc, clr0);
    req = 4'b0000;
    chk("carry_b_hitcnt", 32'(hc), 32'd0);
    chk("carry_b_id", 32'(id), 32'd1);

    // Reset during the third stream cycle of a 6-bit burst
    setpat(0, 255'b101101, 6);
    @(negedge clk);
    req = 4'b0001;
    len = 8'd6;
    repeat (4) @(negedge clk);
    chk("mid_busy_before", 32'(busy), 32'd1);
    chk("mid_gnt_before", 32'(gnt), 32'b0001);
    req = 4'b0000;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_gnt", 32'(gnt), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_hitcnt", 32'(hit_cnt), 32'd0);
    chk("mid_clr", 32'(det_clr), 32'd1);
    rst = 1'b0;
    dcount = int'(done);
    repeat (4) begin
      @(negedge clk);
      dcount += int'(done);
    end
    chk("mid_no_done", 32'(dcount), 32'd0);
    setpat(0, 255'b0, 1);
    run_burst(4'b1111, 8'd1, g1, gcyc, lat, id, hc, clr0);
    req = 4'b0000;
    chk("mid_ptr_zero", 32'(g1), 32'b0001);
    @(negedge clk);
    run_burst(4'b0010, 8'd2, g1, gcyc, lat, id, hc, clr0);
    req = 4'b0000;
    chk("mid_next_gnt", 32'(g1), 32'b0010);
    chk("mid_next_id", 32'(id), 32'd1);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
